// File: rtl/sync_ram_ctrl.sv
// sync_ram_ctrl: single-port synchronous RAM with registered read data,
// a read-valid strobe, a built-in clear engine that sweeps FILL into every
// word after reset or on a soft-clear request, and a selectable
// read-during-write mode.
//
// Access handshake: a request is en=1 sampled on a rising clk edge while
// busy=0; wr selects write (1) or read (0). There is no backpressure: every
// request presented while busy=0 is accepted on that edge, and every request
// presented while busy=1 is silently dropped. A read is answered exactly one
// cycle later by rd_valid=1 with data_out holding the word. With WR_FIRST=1
// a write is answered the same way with data_out = data_in. rd_valid is a
// single-cycle strobe per accepted request and never stalls.
module sync_ram_ctrl #(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [DATA_W-1:0]    FILL     = '0,
    parameter bit                   WR_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              state_dbg
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Two-state controller: CLEAR sweeps the array, READY serves accesses.
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cptr;
    logic                last_clear;

    logic                rd_fire;
    logic                wr_fire;
    logic                clr_fire;
    logic                sweep_we;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    // The sweep ends on the edge that writes the highest address.
    assign last_clear = (cptr == ADDR_W'(DEPTH - 1));

    // State register; reset restarts the sweep from scratch, even mid-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave CLEAR after the last word; re-enter on clr in READY only.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: begin
                if (last_clear) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (clr) begin
                    state_nxt = S_CLEAR;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Output decode: which array operation, if any, happens on this edge.
    // clr inside CLEAR is deliberately ignored so a sweep is never extended.
    always_comb begin
        rd_fire   = 1'b0;
        wr_fire   = 1'b0;
        clr_fire  = 1'b0;
        sweep_we  = 1'b0;
        busy      = 1'b1;
        state_dbg = 1'b0;
        case (state)
            S_CLEAR: begin
                sweep_we  = 1'b1;
                busy      = 1'b1;
                state_dbg = 1'b0;
            end
            S_READY: begin
                rd_fire   = en & ~wr;
                wr_fire   = en & wr;
                clr_fire  = clr;
                busy      = 1'b0;
                state_dbg = 1'b1;
            end
            default: begin
                busy      = 1'b1;
                state_dbg = 1'b0;
            end
        endcase
    end

    // Clear pointer: zero on reset or soft clear, advances once per sweep edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cptr <= '0;
        end else if (state == S_CLEAR) begin
            cptr <= cptr + 1'b1;
        end else if (clr_fire) begin
            cptr <= '0;
        end
    end

    // Array write port select: the sweep owns the port while clearing.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data_in;
        if (!rst) begin
            if (sweep_we) begin
                mem_we    = 1'b1;
                mem_waddr = cptr;
                mem_wdata = FILL;
            end else if (wr_fire) begin
                mem_we    = 1'b1;
                mem_waddr = addr;
                mem_wdata = data_in;
            end
        end
    end

    // Storage array; never reset directly, only swept by the clear engine.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read port and strobe; data_out holds unless a read (or a
    // write in write-first mode) updates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else if (rd_fire) begin
            data_out <= mem[addr];
            rd_valid <= 1'b1;
        end else if (wr_fire && WR_FIRST) begin
            data_out <= data_in;
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Bench for sync_ram_ctrl: two instances driven with identical stimulus,
// one read-first with FILL=8'hA5 and one write-first with FILL=8'h5A.
// A behavioural model pushes expected read data into per-instance queues
// when a request is driven; the queues are popped when rd_valid appears.
module tb_sync_ram_ctrl;

    localparam logic [7:0] FILL0 = 8'hA5;
    localparam logic [7:0] FILL1 = 8'h5A;

    logic       clk;
    logic       rst;
    logic       en;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       clr;

    logic [7:0] data_out0, data_out1;
    logic       rd_valid0, rd_valid1;
    logic       busy0, busy1;
    logic       state_dbg0, state_dbg1;

    int vectors;
    int miscompares;

    // Reference model state
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic       mdl_busy;
    logic [7:0] mdl_cptr;
    logic [7:0] mdl_dout0;
    logic [7:0] mdl_dout1;

    sync_ram_ctrl #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .FILL     (FILL0),
        .WR_FIRST (1'b0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .clr       (clr),
        .data_out  (data_out0),
        .rd_valid  (rd_valid0),
        .busy      (busy0),
        .state_dbg (state_dbg0)
    );

    sync_ram_ctrl #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .FILL     (FILL1),
        .WR_FIRST (1'b1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .clr       (clr),
        .data_out  (data_out1),
        .rd_valid  (rd_valid1),
        .busy      (busy1),
        .state_dbg (state_dbg1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [7:0] x;
        chk("busy0", 32'(busy0), 32'(mdl_busy));
        chk("busy1", 32'(busy1), 32'(mdl_busy));
        chk("state_dbg0", 32'(state_dbg0), 32'(!mdl_busy));
        if (exp_q0.size() > 0) begin
            x = exp_q0.pop_front();
            chk("rd_valid0", 32'(rd_valid0), 32'd1);
            chk("data_out0", 32'(data_out0), 32'(x));
            mdl_dout0 = x;
        end else begin
            chk("rd_valid0", 32'(rd_valid0), 32'd0);
            chk("data_out0_hold", 32'(data_out0), 32'(mdl_dout0));
        end
        if (exp_q1.size() > 0) begin
            x = exp_q1.pop_front();
            chk("rd_valid1", 32'(rd_valid1), 32'd1);
            chk("data_out1", 32'(data_out1), 32'(x));
            mdl_dout1 = x;
        end else begin
            chk("rd_valid1", 32'(rd_valid1), 32'd0);
            chk("data_out1_hold", 32'(data_out1), 32'(mdl_dout1));
        end
    endtask

    // Driver: apply one cycle of inputs, update the model, check after the edge.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic [7:0] a, input logic [7:0] d, input logic c);
        rst     = r;
        en      = e;
        wr      = w;
        addr    = a;
        data_in = d;
        clr     = c;
        if (r) begin
            mdl_busy  = 1'b1;
            mdl_cptr  = 8'h00;
            mdl_dout0 = 8'h00;
            mdl_dout1 = 8'h00;
        end else if (mdl_busy) begin
            mem0[mdl_cptr] = FILL0;
            mem1[mdl_cptr] = FILL1;
            if (mdl_cptr == 8'hFF) mdl_busy = 1'b0;
            mdl_cptr = mdl_cptr + 8'h01;
        end else begin
            if (e && !w) begin
                exp_q0.push_back(mem0[a]);
                exp_q1.push_back(mem1[a]);
            end
            if (e && w) begin
                mem0[a] = d;
                mem1[a] = d;
                exp_q1.push_back(d);
            end
            if (c) begin
                mdl_busy = 1'b1;
                mdl_cptr = 8'h00;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b0);
    endtask

    task automatic wrt(input logic [7:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, 1'b1, a, d, 1'b0);
    endtask

    // Runs while the DUT reports busy, hammering accesses (which must be
    // dropped) and pulsing clr once; returns the number of clearing edges.
    task automatic run_clear(output int n, input int clr_at);
        n = 0;
        while (busy0 === 1'b1 && n < 400) begin
            step(1'b0, 1'b1, 1'(n % 2), 8'h20, 8'hFF, n == clr_at);
            n++;
        end
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        mdl_busy    = 1'b1;
        mdl_cptr    = 8'h00;
        mdl_dout0   = 8'h00;
        mdl_dout1   = 8'h00;

        // Reset for two cycles, then the power-on sweep with accesses ignored
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h20, 8'hFF, 1'b1);
        run_clear(n, 50);
        chk("reset_clear_edges", 32'(n), 32'd256);

        // Fill check, including the address written while busy
        rd(8'h00);
        rd(8'd127);
        rd(8'hFF);
        rd(8'h20);
        idle();

        // Writes then back-to-back reads
        wrt(8'h10, 8'h3C);
        wrt(8'hFF, 8'hC3);
        rd(8'h10);
        rd(8'hFF);
        idle();

        // Write-first visibility and read-after-write
        wrt(8'h05, 8'h77);
        idle();
        rd(8'h05);
        wrt(8'h06, 8'h12);
        rd(8'h06);
        idle();

        // Soft clear issued together with a read: the read still completes
        wrt(8'h01, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
        run_clear(n, 60);
        chk("soft_clear_edges", 32'(n), 32'd256);
        rd(8'h01);
        rd(8'h10);
        idle();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end
        idle();

        // Reset at clear cycle 100 restarts a full sweep
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 99; i++) idle();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        run_clear(n, 40);
        chk("rst_mid_clear_edges", 32'(n), 32'd256);
        rd(8'h05);
        rd(8'h01);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
